// File: rtl/exp2_accum_if.sv
// Handshake/data bundle for exp2_accum: upstream (u, v, flags) and downstream (exp_out, sum_out) sides.
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 32
`endif
`ifndef FIXPOINT_FRAC
`define FIXPOINT_FRAC 10
`endif

interface exp2_accum_if;
    logic                            in_valid;
    logic                            in_ready;
    logic [`OUTPUT_BUF_DATASIZE-1:0] u;
    logic [`FIXPOINT_FRAC-1:0]       v;
    logic                            is_stage2;
    logic                            in_last;
    logic                            out_valid;
    logic                            out_ready;
    logic [`OUTPUT_BUF_DATASIZE-1:0] exp_out;
    logic                            sum_valid;
    logic [`OUTPUT_BUF_DATASIZE-1:0] sum_out;

    modport master (
        output in_valid, u, v, is_stage2, in_last, out_ready,
        input  in_ready, out_valid, exp_out, sum_valid, sum_out
    );

    modport slave (
        input  in_valid, u, v, is_stage2, in_last, out_ready,
        output in_ready, out_valid, exp_out, sum_valid, sum_out
    );
endinterface

// File: rtl/exp2_accum.sv
// 2^(u+v) fixed-point evaluator with saturating per-row accumulator; POW2_LUT_CORR_EN enables mantissa LUT correction.
// Latency: 3 cycles from input accept to out_valid; sum_valid one cycle after the row's last output beat.
// Backpressure: single global advance (out_ready | ~out_valid) drives in_ready and freezes every stage.
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 32
`endif
`ifndef FIXPOINT_FRAC
`define FIXPOINT_FRAC 10
`endif

module exp2_accum (
    input  logic        clk,
    input  logic        rst,
    exp2_accum_if.slave bus
);
    localparam int DW = `OUTPUT_BUF_DATASIZE;
    localparam int FW = `FIXPOINT_FRAC;
    localparam int MW = FW + 1;

    logic          r_s1_vld, r_s1_s2, r_s1_last;
    logic [DW-1:0] r_s1_u;
    logic [MW-1:0] r_s1_m;
    logic          r_s2_vld, r_s2_s2, r_s2_last;
    logic [DW-1:0] r_s2_val;
    logic          r_out_vld, r_out_s2, r_out_last;
    logic [DW-1:0] r_exp_out;
    logic [31:0]   r_sum;
    logic          r_sum_vld;
    logic [DW-1:0] r_sum_out;

    logic          w_adv;
    logic          w_out_beat;
    logic [6:0]    w_corr;
    logic [MW-1:0] w_m;
    logic [DW-1:0] w_m_ext;
    logic [3:0]    w_rsh;
    logic [DW-1:0] w_shift;
    logic [32:0]   w_sum_add;
    logic [31:0]   w_sum_sat;

    assign w_adv      = bus.out_ready | ~r_out_vld;
    assign w_out_beat = r_out_vld & bus.out_ready;

`ifdef POW2_LUT_CORR_EN
    // Chord-to-curve correction of 1+v, sampled at the midpoint of each 1/16 segment.
    function automatic logic [6:0] f_corr(input logic [3:0] idx);
        case (idx)
            4'd0:    f_corr = 7'd10;
            4'd1:    f_corr = 7'd27;
            4'd2:    f_corr = 7'd43;
            4'd3:    f_corr = 7'd56;
            4'd4:    f_corr = 7'd68;
            4'd5:    f_corr = 7'd76;
            4'd6:    f_corr = 7'd83;
            4'd7:    f_corr = 7'd87;
            4'd8:    f_corr = 7'd88;
            4'd9:    f_corr = 7'd87;
            4'd10:   f_corr = 7'd82;
            4'd11:   f_corr = 7'd75;
            4'd12:   f_corr = 7'd64;
            4'd13:   f_corr = 7'd50;
            4'd14:   f_corr = 7'd33;
            default: f_corr = 7'd12;
        endcase
    endfunction
    assign w_corr = f_corr(bus.v[FW-1 -: 4]);
`else
    assign w_corr = '0;
`endif

    assign w_m     = {1'b1, {FW{1'b0}}} + {1'b0, bus.v} - {{(MW-7){1'b0}}, w_corr};
    assign w_m_ext = {{(DW-MW){1'b0}}, r_s1_m};
    // Only -10..-1 reach the right-shift path, so the low nibble of -u is the full amount.
    assign w_rsh   = ~r_s1_u[3:0] + 4'd1;

    always_comb begin
        w_shift = '0;
        if ($signed(r_s1_u) >= 22)
            w_shift = '1;
        else if ($signed(r_s1_u) <= -11)
            w_shift = '0;
        else if (!r_s1_u[DW-1])
            w_shift = w_m_ext << r_s1_u[4:0];
        else
            w_shift = w_m_ext >> w_rsh;
    end

    assign w_sum_add = {1'b0, r_sum} + {1'b0, r_exp_out};
    assign w_sum_sat = w_sum_add[32] ? 32'hFFFF_FFFF : w_sum_add[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_s2    <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_u     <= '0;
            r_s1_m     <= '0;
            r_s2_vld   <= 1'b0;
            r_s2_s2    <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_val   <= '0;
            r_out_vld  <= 1'b0;
            r_out_s2   <= 1'b0;
            r_out_last <= 1'b0;
            r_exp_out  <= '0;
            r_sum      <= '0;
            r_sum_vld  <= 1'b0;
            r_sum_out  <= '0;
        end else begin
            if (w_adv) begin
                r_s1_vld   <= bus.in_valid;
                r_s1_s2    <= bus.is_stage2;
                r_s1_last  <= bus.in_last;
                r_s1_u     <= bus.u;
                r_s1_m     <= w_m;
                r_s2_vld   <= r_s1_vld;
                r_s2_s2    <= r_s1_s2;
                r_s2_last  <= r_s1_last;
                r_s2_val   <= w_shift;
                r_out_vld  <= r_s2_vld;
                r_out_s2   <= r_s2_s2;
                r_out_last <= r_s2_last;
                r_exp_out  <= r_s2_val;
            end
            r_sum_vld <= 1'b0;
            if (w_out_beat && r_out_s2) begin
                if (r_out_last) begin
                    r_sum_out <= w_sum_sat;
                    r_sum_vld <= 1'b1;
                    r_sum     <= '0;
                end else begin
                    r_sum     <= w_sum_sat;
                end
            end
        end
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_out_vld;
    assign bus.exp_out   = r_exp_out;
    assign bus.sum_valid = r_sum_vld;
    assign bus.sum_out   = r_sum_out;
endmodule

// File: tb/tb_exp2_accum.sv
// Randomized and directed bench for exp2_accum against a plain-arithmetic reference of 2^(u+v) and row sums.
module tb_exp2_accum;
    localparam int PER = 10;

    logic clk = 1'b0;
    logic rst;
    always #(PER/2) clk = ~clk;

    exp2_accum_if ifc();
    exp2_accum dut (.clk(clk), .rst(rst), .bus(ifc));

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic [31:0] exp_sum_q[$];
    logic [31:0] obs_sum_q[$];
    logic [31:0] model_sum;
    bit          rand_done;

    function automatic int corr_of(int v);
`ifdef POW2_LUT_CORR_EN
        real x;
        x = ((v / 64) + 0.5) / 16.0;
        return $rtoi(1024.0 * (1.0 + x - $pow(2.0, x)) + 0.5);
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] exp_model(int u, int v);
        longint m;
        m = 1024 + v - corr_of(v);
        if (u >= 22)  return 32'hFFFF_FFFF;
        if (u <= -11) return 32'h0;
        if (u >= 0)   return 32'(m << u);
        return 32'(m >> (-u));
    endfunction

    function automatic logic [31:0] sat_add(logic [31:0] a, logic [31:0] b);
        longint s;
        s = longint'(a) + longint'(b);
        if (s > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
        return 32'(s);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.out_valid && ifc.out_ready) obs_q.push_back(ifc.exp_out);
            if (ifc.sum_valid) obs_sum_q.push_back(ifc.sum_out);
        end
    end

    task automatic clear_model();
        exp_q.delete();
        obs_q.delete();
        exp_sum_q.delete();
        obs_sum_q.delete();
        model_sum = '0;
    endtask

    // Presents one beat and returns at posedge+1 after it was accepted.
    task automatic send_beat(input int u, input int v, input bit s2, input bit last);
        logic [31:0] e;
        bit ok;
        ok = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.u         = u;
        ifc.v         = 10'(v);
        ifc.is_stage2 = s2;
        ifc.in_last   = last;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (ifc.in_ready) begin
                ok = 1'b1;
                e  = exp_model(u, v);
                exp_q.push_back(e);
                if (s2) begin
                    model_sum = sat_add(model_sum, e);
                    if (last) begin
                        exp_sum_q.push_back(model_sum);
                        model_sum = '0;
                    end
                end
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 100 cycles");
        end
    endtask

    task automatic wait_drain();
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        for (int n = 0; n < 200 && obs_q.size() < exp_q.size(); n++) begin
            @(posedge clk); #1;
        end
        repeat (3) begin @(posedge clk); #1; end
        if (obs_q.size() < exp_q.size()) begin
            checks++; failures++;
            $display("FAIL drain_timeout: outputs=%0d required=%0d", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        ifc.in_valid  = 1'b1;
        ifc.u         = 32'd5;
        ifc.v         = 10'd100;
        ifc.is_stage2 = 1'b1;
        ifc.in_last   = 1'b1;
        ifc.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 ifc.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
        checks++; if (ifc.sum_valid !== 1'b0) begin failures++; $display("FAIL reset_sum_valid: got %b want 0", ifc.sum_valid); end
        checks++; if (ifc.exp_out !== 32'h0) begin failures++; $display("FAIL reset_exp_out: got %h want 0", ifc.exp_out); end
        checks++; if (ifc.sum_out !== 32'h0) begin failures++; $display("FAIL reset_sum_out: got %h want 0", ifc.sum_out); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int          u_tab [5];
        int          v_tab [5];
        logic [31:0] want  [5];
        int          lat;
        u_tab = '{0, 3, -11, 22, 21};
        v_tab = '{0, 512, 1023, 0, 0};
`ifdef POW2_LUT_CORR_EN
        want  = '{32'h0000_03F6, 32'h0000_2D40, 32'h0, 32'hFFFF_FFFF, 32'h7EC0_0000};
`else
        want  = '{32'h0000_0400, 32'h0000_3000, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000};
`endif
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ifc.in_valid  = 1'b1;
            ifc.u         = u_tab[i];
            ifc.v         = 10'(v_tab[i]);
            ifc.is_stage2 = 1'b0;
            ifc.in_last   = 1'b0;
            @(negedge clk);
            checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL dir%0d_accept: in_ready %b want 1", i, ifc.in_ready); end
            @(posedge clk); #1 ifc.in_valid = 1'b0;
            lat = 0;
            for (int n = 1; n <= 10 && lat == 0; n++) begin
                @(negedge clk);
                if (ifc.out_valid) lat = n;
            end
            checks++; if (lat != 3) begin failures++; $display("FAIL dir%0d_latency: got %0d want 3", i, lat); end
            checks++; if (ifc.exp_out !== want[i]) begin failures++; $display("FAIL dir%0d_exp_out: got %h want %h", i, ifc.exp_out, want[i]); end
            @(posedge clk); #1;
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_accum();
        time         t0;
        logic [31:0] row1, row2;
`ifdef POW2_LUT_CORR_EN
        row1 = 32'h0BE2; row2 = 32'h07EC;
`else
        row1 = 32'h0C00; row2 = 32'h0800;
`endif
        clear_model();
        ifc.out_ready = 1'b1;
        t0 = $time;
        send_beat(0, 0, 1'b1, 1'b0);
        send_beat(0, 0, 1'b1, 1'b0);
        send_beat(0, 0, 1'b1, 1'b1);
        checks++; if ($time - t0 != 3 * PER) begin failures++; $display("FAIL b2b_accept: took %0t want %0d", $time - t0, 3 * PER); end
        send_beat(2, 0, 1'b0, 1'b1);
        send_beat(0, 0, 1'b1, 1'b0);
        send_beat(0, 0, 1'b1, 1'b1);
        wait_drain();
        checks++;
        if (obs_sum_q.size() != 2) begin
            failures++; $display("FAIL accum_pulses: got %0d want 2", obs_sum_q.size());
        end else begin
            checks++; if (obs_sum_q[0] !== row1) begin failures++; $display("FAIL accum_row1: got %h want %h", obs_sum_q[0], row1); end
            checks++; if (obs_sum_q[1] !== row2) begin failures++; $display("FAIL accum_row2: got %h want %h", obs_sum_q[1], row2); end
        end
        @(negedge clk);
        checks++; if (ifc.sum_out !== row2) begin failures++; $display("FAIL accum_hold: got %h want %h", ifc.sum_out, row2); end
        checks++; if (ifc.sum_valid !== 1'b0) begin failures++; $display("FAIL accum_pulse_len: sum_valid %b want 0", ifc.sum_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        clear_model();
        ifc.out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send_beat(int'($urandom_range(0, 15)) - 5, int'($urandom_range(0, 1023)), 1'b0, 1'b0);
                ifc.in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 ifc.out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    checks++; if (ifc.out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid: got %b want 1", ifc.out_valid); end
                    checks++; if (ifc.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready: got %b want 0", ifc.in_ready); end
                    checks++;
                    if (obs_q.size() >= exp_q.size()) begin
                        failures++; $display("FAIL stall_exp_out: got %h want no pending beat", ifc.exp_out);
                    end else if (ifc.exp_out !== exp_q[obs_q.size()]) begin
                        failures++; $display("FAIL stall_exp_out: got %h want %h", ifc.exp_out, exp_q[obs_q.size()]);
                    end
                    @(posedge clk); #1;
                end
                ifc.out_ready = 1'b1;
            end
        join
        wait_drain();
        checks++; if (obs_q.size() != 5) begin failures++; $display("FAIL bp_count: got %0d want 5", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        clear_model();
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    ifc.in_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send_beat(int'($urandom_range(0, 38)) - 14, int'($urandom_range(0, 1023)),
                              ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
                end
                ifc.in_valid = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    ifc.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        wait_drain();
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (obs_sum_q.size() != exp_sum_q.size()) begin failures++; $display("FAIL rand_sum_count: got %0d want %0d", obs_sum_q.size(), exp_sum_q.size()); end
        for (int i = 0; i < obs_sum_q.size() && i < exp_sum_q.size(); i++) begin
            checks++; if (obs_sum_q[i] !== exp_sum_q[i]) begin failures++; $display("FAIL rand_sum%0d: got %h want %h", i, obs_sum_q[i], exp_sum_q[i]); end
        end
    endtask

    task automatic test_reset_midrow();
        logic [31:0] want;
`ifdef POW2_LUT_CORR_EN
        want = 32'h03F6;
`else
        want = 32'h0400;
`endif
        clear_model();
        ifc.out_ready = 1'b1;
        send_beat(0, 0, 1'b1, 1'b0);
        send_beat(0, 0, 1'b1, 1'b0);
        ifc.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (ifc.sum_out !== 32'h0) begin failures++; $display("FAIL midrow_sum_out_clr: got %h want 0", ifc.sum_out); end
        checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL midrow_out_valid: got %b want 0", ifc.out_valid); end
        @(posedge clk); #1 rst = 1'b0;
        clear_model();
        send_beat(0, 0, 1'b1, 1'b1);
        wait_drain();
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL midrow_outputs: got %0d want 1", obs_q.size()); end
        checks++;
        if (obs_sum_q.size() != 1) begin
            failures++; $display("FAIL midrow_pulses: got %0d want 1", obs_sum_q.size());
        end else if (obs_sum_q[0] !== want) begin
            failures++; $display("FAIL midrow_sum: got %h want %h", obs_sum_q[0], want);
        end
    endtask

    initial begin
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.u         = '0;
        ifc.v         = '0;
        ifc.is_stage2 = 1'b0;
        ifc.in_last   = 1'b0;
        ifc.out_ready = 1'b0;
        model_sum     = '0;
        rand_done     = 1'b0;
        #1;
        test_reset();
        test_directed();
        test_accum();
        test_backpressure();
        test_random();
        test_reset_midrow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(40000 * PER);
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
